// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared constants and types for the 640x480@60 Hz VGA timing
//               generator: default porch/sync/visible widths, derived line
//               and frame totals, coordinate width and color bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Coordinate counters are unsigned 12-bit, so totals are limited to 4096.
    localparam int c_coord_w   = 12;

    // Default 640x480@60 Hz timing, in pixels (horizontal) and lines (vertical)
    localparam int c_h_visible = 640;
    localparam int c_h_front   = 16;
    localparam int c_h_sync    = 96;
    localparam int c_h_back    = 48;
    localparam int c_v_visible = 480;
    localparam int c_v_front   = 10;
    localparam int c_v_sync    = 2;
    localparam int c_v_back    = 33;

    // Bit positions inside the 3-bit color word
    localparam int c_color_r   = 2;
    localparam int c_color_g   = 1;
    localparam int c_color_b   = 0;

    typedef logic [c_coord_w-1:0] coord_t;
    // One extra bit so that decode bounds equal to 4096 still compare correctly
    typedef logic [c_coord_w:0]   coord_ext_t;
    typedef logic [2:0]           color_t;

    // Length of one axis: visible + front porch + sync + back porch
    function automatic int axis_total(input int vis, input int fp, input int sw, input int bp);
        return vis + fp + sw + bp;
    endfunction

    localparam int c_h_total = axis_total(c_h_visible, c_h_front, c_h_sync, c_h_back);
    localparam int c_v_total = axis_total(c_v_visible, c_v_front, c_v_sync, c_v_back);

endpackage
`default_nettype wire

// File: rtl/vga_timing_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_generator_if
// Description : Pixel coordinate bus between the timing generator (master)
//               and the image generator (slave).
//               x, y  : current raster position, driven by the master
//               color : 3-bit color for (x, y), returned combinationally by
//                       the slave (bit2=R, bit1=G, bit0=B)
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_generator_if;
    import vga_timing_pkg::*;

    coord_t x;
    coord_t y;
    color_t color;

    modport master (
        output x,
        output y,
        input  color
    );

    modport slave (
        input  x,
        input  y,
        output color
    );

endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis counter (horizontal or vertical). Counts
//               0..TOTAL-1 while enabled and decodes the visible and sync
//               regions from the current count.
//   CLOCK_25  in   pixel clock
//   RESET     in   synchronous active-high reset, clears the count
//   en_i      in   advance the count on this edge
//   count_o   out  current count (the register itself)
//   wrap_o    out  enabled and at TOTAL-1: the count returns to 0 this edge
//   visible_o out  count < VISIBLE
//   sync_o    out  SYNC_START <= count < SYNC_START + SYNC_WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = c_h_total,
    parameter int SYNC_START = c_h_visible + c_h_front,
    parameter int SYNC_WIDTH = c_h_sync,
    parameter int VISIBLE    = c_h_visible
) (
    input  logic   CLOCK_25,
    input  logic   RESET,
    input  logic   en_i,
    output coord_t count_o,
    output logic   wrap_o,
    output logic   visible_o,
    output logic   sync_o
);

    localparam coord_t     c_last       = coord_t'(TOTAL - 1);
    localparam coord_ext_t c_visible    = coord_ext_t'(VISIBLE);
    localparam coord_ext_t c_sync_start = coord_ext_t'(SYNC_START);
    localparam coord_ext_t c_sync_end   = coord_ext_t'(SYNC_START + SYNC_WIDTH);

    coord_t     count_q;
    coord_t     count_d;
    logic       w_wrap;
    coord_ext_t w_count_ext;

    assign w_wrap      = en_i && (count_q == c_last);
    assign w_count_ext = {1'b0, count_q};

    always_comb begin
        count_d = count_q;
        if (w_wrap) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + coord_t'(1);
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign wrap_o    = w_wrap;
    assign visible_o = (w_count_ext < c_visible);
    assign sync_o    = (w_count_ext >= c_sync_start) && (w_count_ext < c_sync_end);

endmodule
`default_nettype wire

// File: rtl/vga_timing_generator.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_generator
// Description : 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.
//               Presents (x, y) to the image generator, registers its color
//               together with the sync decodes so RGB and sync arrive at the
//               connector aligned, and pulses frame_start for one cycle when
//               (0, 0) is presented after a frame wrap.
//   CLOCK_25    in   pixel clock
//   RESET       in   synchronous active-high reset
//   pix         bus  master side of the pixel coordinate bus (x, y, color)
//   VGA_HS/VS   out  active-low syncs, one cycle behind (x, y)
//   VGA_R/G/B   out  pixel color, one cycle behind (x, y), 0 in blanking
//   frame_start out  one-cycle pulse with the first (0, 0) of each frame
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = c_h_visible,
    parameter int H_FRONT   = c_h_front,
    parameter int H_SYNC    = c_h_sync,
    parameter int H_BACK    = c_h_back,
    parameter int V_VISIBLE = c_v_visible,
    parameter int V_FRONT   = c_v_front,
    parameter int V_SYNC    = c_v_sync,
    parameter int V_BACK    = c_v_back
) (
    input  logic                          CLOCK_25,
    input  logic                          RESET,
    vga_timing_generator_if.master        pix,
    output logic                          VGA_HS,
    output logic                          VGA_VS,
    output logic                          VGA_R,
    output logic                          VGA_G,
    output logic                          VGA_B,
    output logic                          frame_start
);

    localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    coord_t w_h;
    coord_t w_v;
    logic   w_h_wrap;
    logic   w_v_wrap;
    logic   w_h_vis;
    logic   w_v_vis;
    logic   w_h_sync;
    logic   w_v_sync;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_VISIBLE + H_FRONT),
        .SYNC_WIDTH (H_SYNC),
        .VISIBLE    (H_VISIBLE)
    ) u_h_counter (
        .CLOCK_25  (CLOCK_25),
        .RESET     (RESET),
        .en_i      (1'b1),
        .count_o   (w_h),
        .wrap_o    (w_h_wrap),
        .visible_o (w_h_vis),
        .sync_o    (w_h_sync)
    );

    // The vertical axis steps once per line, on the horizontal wrap; its own
    // wrap therefore marks the last pixel of the frame.
    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_VISIBLE + V_FRONT),
        .SYNC_WIDTH (V_SYNC),
        .VISIBLE    (V_VISIBLE)
    ) u_v_counter (
        .CLOCK_25  (CLOCK_25),
        .RESET     (RESET),
        .en_i      (w_h_wrap),
        .count_o   (w_v),
        .wrap_o    (w_v_wrap),
        .visible_o (w_v_vis),
        .sync_o    (w_v_sync)
    );

    assign pix.x = w_h;
    assign pix.y = w_v;

    // Output stage: everything for pixel (h, v) is captured on the same edge,
    // so sync and color leave the chip together one cycle after (x, y).
    logic   vga_hs_q, vga_hs_d;
    logic   vga_vs_q, vga_vs_d;
    color_t rgb_q, rgb_d;
    logic   frame_start_q, frame_start_d;

    always_comb begin
        vga_hs_d      = ~w_h_sync;
        vga_vs_d      = ~w_v_sync;
        rgb_d         = (w_h_vis && w_v_vis) ? pix.color : '0;
        frame_start_d = w_v_wrap;
    end

    always_ff @(posedge CLOCK_25) begin
        if (RESET) begin
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign VGA_HS      = vga_hs_q;
    assign VGA_VS      = vga_vs_q;
    assign VGA_R       = rgb_q[c_color_r];
    assign VGA_G       = rgb_q[c_color_g];
    assign VGA_B       = rgb_q[c_color_b];
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_generator
// Description : Testbench for vga_timing_generator. Instance A uses the
//               default 640x480 timing (first lines of a frame); instance B
//               uses a reduced raster so full frames, frame wraps and the
//               mid-frame reset restart fit in a short run. A per-instance
//               reference raster model pushes the expected registered
//               outputs into a queue when color is driven; they are popped
//               and compared one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_generator;
    import vga_timing_pkg::*;

    // Reduced timing for instance B: 32 pixels x 19 lines = 608 cycles/frame
    localparam int B_HV = 20, B_HF = 3, B_HS = 5, B_HB = 4;
    localparam int B_VV = 12, B_VF = 2, B_VS = 2, B_VB = 3;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst_a, rst_b;
    logic hs_a, vs_a, r_a, g_a, b_a, fs_a;
    logic hs_b, vs_b, r_b, g_b, b_b, fs_b;

    vga_timing_generator_if bus_a ();
    vga_timing_generator_if bus_b ();

    vga_timing_generator u_dut_a (
        .CLOCK_25    (clk),
        .RESET       (rst_a),
        .pix         (bus_a),
        .VGA_HS      (hs_a),
        .VGA_VS      (vs_a),
        .VGA_R       (r_a),
        .VGA_G       (g_a),
        .VGA_B       (b_a),
        .frame_start (fs_a)
    );

    vga_timing_generator #(
        .H_VISIBLE (B_HV), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
        .V_VISIBLE (B_VV), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB)
    ) u_dut_b (
        .CLOCK_25    (clk),
        .RESET       (rst_b),
        .pix         (bus_b),
        .VGA_HS      (hs_b),
        .VGA_VS      (vs_b),
        .VGA_R       (r_b),
        .VGA_G       (g_b),
        .VGA_B       (b_b),
        .frame_start (fs_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model parameters and state, index 0 = A, 1 = B
    int hvis[2], hss[2], hse[2], htot[2];
    int vvis[2], vss[2], vse[2], vtot[2];
    int mh[2], mv[2];
    bit mfs[2];
    bit all_ones;

    // Expected {HS, VS, R, G, B} for the cycle after the pixel was presented
    logic [4:0] q_a[$];
    logic [4:0] q_b[$];

    int hs_run_a = 0;
    int vs_run_b = 0;
    int fs_count_b = 0;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] decode(input int d, input logic [2:0] c);
        logic hs, vs, vis;
        hs  = !(mh[d] >= hss[d] && mh[d] < hse[d]);
        vs  = !(mv[d] >= vss[d] && mv[d] < vse[d]);
        vis = (mh[d] < hvis[d]) && (mv[d] < vvis[d]);
        return {hs, vs, (vis ? c : 3'b000)};
    endfunction

    // Push the output expected after the coming edge, then move the model on
    task automatic advance(input int d, input bit r, input logic [2:0] c);
        logic [4:0] e;
        if (r) begin
            e      = 5'b11000;
            mh[d]  = 0;
            mv[d]  = 0;
            mfs[d] = 1'b0;
        end else begin
            e      = decode(d, c);
            mfs[d] = 1'b0;
            if (mh[d] == htot[d] - 1) begin
                mh[d] = 0;
                if (mv[d] == vtot[d] - 1) begin
                    mv[d]  = 0;
                    mfs[d] = 1'b1;
                end else begin
                    mv[d]++;
                end
            end else begin
                mh[d]++;
            end
        end
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    // One clock: compare at the falling edge, then drive inputs for the next rise
    task automatic step(input bit ra, input bit rb);
        logic [4:0] ea, eb;
        logic [2:0] ca, cb;
        @(negedge clk);
        chk("x_a",  bus_a.x, 12'(mh[0]));
        chk("y_a",  bus_a.y, 12'(mv[0]));
        chk("fs_a", {11'b0, fs_a}, {11'b0, mfs[0]});
        ea = q_a.pop_front();
        chk("out_a", {7'b0, hs_a, vs_a, r_a, g_a, b_a}, {7'b0, ea});
        chk("x_b",  bus_b.x, 12'(mh[1]));
        chk("y_b",  bus_b.y, 12'(mv[1]));
        chk("fs_b", {11'b0, fs_b}, {11'b0, mfs[1]});
        eb = q_b.pop_front();
        chk("out_b", {7'b0, hs_b, vs_b, r_b, g_b, b_b}, {7'b0, eb});

        // Sync pulse widths, measured directly on the outputs
        if (hs_a === 1'b0) hs_run_a++;
        else begin
            if (hs_run_a != 0) chk("hs_run_a", 12'(hs_run_a), 12'(c_h_sync));
            hs_run_a = 0;
        end
        if (vs_b === 1'b0) vs_run_b++;
        else begin
            if (vs_run_b != 0) chk("vs_run_b", 12'(vs_run_b), 12'(B_VS * 32));
            vs_run_b = 0;
        end
        if (fs_b === 1'b1) fs_count_b++;

        ca = all_ones ? 3'b111 : 3'($urandom_range(0, 7));
        cb = all_ones ? 3'b111 : 3'($urandom_range(0, 7));
        bus_a.color = ca;
        bus_b.color = cb;
        rst_a = ra;
        rst_b = rb;
        advance(0, ra, ca);
        advance(1, rb, cb);
    endtask

    initial begin
        hvis[0] = c_h_visible;
        hss[0]  = c_h_visible + c_h_front;
        hse[0]  = c_h_visible + c_h_front + c_h_sync;
        htot[0] = 800;
        vvis[0] = c_v_visible;
        vss[0]  = c_v_visible + c_v_front;
        vse[0]  = c_v_visible + c_v_front + c_v_sync;
        vtot[0] = 525;
        hvis[1] = B_HV;
        hss[1]  = B_HV + B_HF;
        hse[1]  = B_HV + B_HF + B_HS;
        htot[1] = 32;
        vvis[1] = B_VV;
        vss[1]  = B_VV + B_VF;
        vse[1]  = B_VV + B_VF + B_VS;
        vtot[1] = 19;

        // First edge is a reset edge for both instances
        all_ones    = 1'b1;
        rst_a       = 1'b1;
        rst_b       = 1'b1;
        bus_a.color = 3'b111;
        bus_b.color = 3'b111;
        for (int d = 0; d < 2; d++) begin
            mh[d]  = 0;
            mv[d]  = 0;
            mfs[d] = 1'b0;
        end
        q_a.push_back(5'b11000);
        q_b.push_back(5'b11000);

        // Reset held for three edges in total, then released
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Constant white: blanking, line wraps, HS on A, frame wraps on B
        for (int i = 0; i < 1700; i++) step(1'b0, 1'b0);

        // Random colors from here on
        all_ones = 1'b0;

        // Mid-line reset of A at x=300
        for (int i = 0; i < 900 && mh[0] != 300; i++) step(1'b0, 1'b0);
        chk("reach_a_300", 12'(mh[0]), 12'd300);
        step(1'b1, 1'b0);

        // Mid-frame reset of B at (10, 7), then a full frame and a bit more
        for (int i = 0; i < 700 && !(mh[1] == 10 && mv[1] == 7); i++) step(1'b0, 1'b0);
        chk("reach_b_10_7", 12'(mh[1] * 16 + mv[1]), 12'(10 * 16 + 7));
        step(1'b0, 1'b1);
        fs_count_b = 0;
        for (int i = 0; i < 607; i++) step(1'b0, 1'b0);
        // No pulse may appear before the first full frame after reset
        chk("fs_b_quiet", 12'(fs_count_b), 12'd0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
        chk("fs_b_once", 12'(fs_count_b), 12'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
